// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the digit-serial subtractor.
// No logic; only the FSM state encoding and digit width.
// Imported by the top and the 2-bit slice.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int DIGIT_W = 2;

endpackage

// File: rtl/two_bit_subtractor.sv
// 2-bit ripple-borrow subtract slice: {bout, diff} = a - b - bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller sequences the slice.
module two_bit_subtractor
  import serial_sub_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               bin_i,
  output logic [DIGIT_W-1:0] diff_o,
  output logic               bout_o,
  output logic               bmid_o
);

  // Full-subtractor per bit; bmid_o is the borrow from bit 0 into bit 1,
  // which on the top digit is the borrow into the word MSB.
  always_comb begin
    diff_o[0] = a_i[0] ^ b_i[0] ^ bin_i;
    bmid_o    = (~a_i[0] & b_i[0]) | (~a_i[0] & bin_i) | (b_i[0] & bin_i);
    diff_o[1] = a_i[1] ^ b_i[1] ^ bmid_o;
    bout_o    = (~a_i[1] & b_i[1]) | (~a_i[1] & bmid_o) | (b_i[1] & bmid_o);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - Bin, two bits per clock, LSB first.
// Latency: accept at edge E0, out_valid after edge E(NUM_DIGITS).
// Backpressure: in_ready low in RUN/DONE; result held in DONE until out_ready.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             ovf,
  output logic             busy
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be even and >= 2");
    end
  endgenerate

  sub_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] a_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] b_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic [DIGIT_W-1:0] slice_d;
  logic               slice_bout;
  logic               slice_bmid;

  // The single slice is time-shared across digits; cnt_q selects the digit.
  two_bit_subtractor u_slice (
    .a_i    (a_q[cnt_q]),
    .b_i    (b_q[cnt_q]),
    .bin_i  (borrow_q),
    .diff_o (slice_d),
    .bout_o (slice_bout),
    .bmid_o (slice_bmid)
  );

  // FSM, operand capture, borrow chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= Bin;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          diff_q[cnt_q] <= slice_d;
          borrow_q      <= slice_bout;
          cnt_q         <= cnt_q + 1'b1;
          if (cnt_q == LAST_DIGIT) begin
            bout_q  <= slice_bout;
            ovf_q   <= slice_bmid ^ slice_bout;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = diff_q;
  assign Bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed and random operands
// checked against an integer-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         Bout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .Bout      (Bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: returns {ovf, Bout, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra,
                                           input logic [W-1:0] rb,
                                           input logic rbin);
    int ud;
    int sd;
    logic [W-1:0] d;
    logic bo;
    logic ov;
    ud = int'(ra) - int'(rb) - int'(rbin);
    sd = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    d  = ud[W-1:0];
    bo = (ud < 0);
    ov = (sd > 127) || (sd < -128);
    return {ov, bo, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair and waits for out_valid; leaves the DUT in DONE.
  // lat is the number of edges from acceptance to out_valid (-1 on timeout).
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic obin, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    a = oa;
    b = ob;
    Bin = obin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Operand changes after acceptance must not matter.
    a = W'($urandom);
    b = W'($urandom);
    Bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    Bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, busy, diff, Bout, ovf} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: ov=%b ir=%b busy=%b diff=%h Bout=%b ovf=%b, want 0 1 0 00 0 0",
               out_valid, in_ready, busy, diff, Bout, ovf);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{8'h05, 8'h03, 8'h80, 8'h00};
    logic [W-1:0] vb [4] = '{8'h03, 8'h05, 8'h01, 8'h00};
    logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W+1:0] want [4] = '{{1'b0, 1'b0, 8'h02}, {1'b0, 1'b1, 8'hFE},
                              {1'b1, 1'b0, 8'h7F}, {1'b0, 1'b1, 8'hFF}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], lat);
      total++;
      if (lat !== 4) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want 4", i, lat);
      end
      total++;
      if ({ovf, Bout, diff} !== want[i] || {ovf, Bout, diff} !== ref_sub(va[i], vb[i], vc[i])) begin
        bad++;
        $display("FAIL directed_result[%0d]: ovf/Bout/diff=%b/%b/%h, want %b/%b/%h",
                 i, ovf, Bout, diff, want[i][W+1], want[i][W], want[i][W-1:0]);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL directed_release[%0d]: out_valid=%b in_ready=%b, want 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic [W+1:0] exp_v;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp_v = ref_sub(ra, rb, rc);
      do_op(ra, rb, rc, lat);
      total++;
      if (lat !== 4 || {ovf, Bout, diff} !== exp_v) begin
        bad++;
        $display("FAIL random[%0d]: a=%h b=%h Bin=%b lat=%0d got %b/%b/%h, want 4 %b/%b/%h",
                 i, ra, rb, rc, lat, ovf, Bout, diff, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] held;
    int lat;
    out_ready = 1'b0;
    do_op(8'h3C, 8'h5A, 1'b1, lat);
    held = {ovf, Bout, diff};
    total++;
    if (held !== ref_sub(8'h3C, 8'h5A, 1'b1) || lat !== 4) begin
      bad++;
      $display("FAIL bp_result: lat=%0d got %b/%b/%h", lat, held[W+1], held[W], held[W-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 8'hAA;
        b = 8'h11;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      total++;
      if ({ovf, Bout, diff} !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: result=%b/%b/%h in_ready=%b out_valid=%b",
                 i, ovf, Bout, diff, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
    // The AA pulse during DONE must not have started an operation.
    tick();
    total++;
    if (busy !== 1'b0 || {ovf, Bout, diff} !== held) begin
      bad++;
      $display("FAIL bp_ignored_in: busy=%b result=%b/%b/%h", busy, ovf, Bout, diff);
    end
  endtask

  task automatic test_abort();
    int seen;
    int lat;
    a = 8'h77;
    b = 8'h22;
    Bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || diff !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_state: out_valid=%b diff=%h busy=%b in_ready=%b, want 0 00 0 1",
               out_valid, diff, busy, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_result: out_valid seen %0d times, want 0", seen);
    end
    do_op(8'h10, 8'h01, 1'b0, lat);
    total++;
    if (diff !== 8'h0F || Bout !== 1'b0 || ovf !== 1'b0 || lat !== 4) begin
      bad++;
      $display("FAIL abort_next_op: diff=%h Bout=%b ovf=%b lat=%0d, want 0F 0 0 4",
               diff, Bout, ovf, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    logic [W+1:0] exp2;
    exp2 = ref_sub(8'hC3, 8'h4D, 1'b1);
    do_op(8'h21, 8'h12, 1'b0, lat);
    // Offer the next pair while still in DONE; it is taken only once IDLE.
    a = 8'hC3;
    b = 8'h4D;
    Bin = 1'b1;
    in_valid = 1'b1;
    gap = 0;
    while (!(busy && !out_valid) && gap < 20) begin
      tick();
      gap++;
    end
    in_valid = 1'b0;
    total++;
    if (gap !== 2) begin
      bad++;
      $display("FAIL b2b_gap: next accept %0d edges after out_valid, want 2", gap);
    end
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 4 || {ovf, Bout, diff} !== exp2) begin
      bad++;
      $display("FAIL b2b_result: lat=%0d got %b/%b/%h, want 4 %b/%b/%h",
               lat, ovf, Bout, diff, exp2[W+1], exp2[W], exp2[W-1:0]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
